// File: rtl/red_pitaya_normalizer_integrator_if.sv
// Handshake/data bundle between the normalizer and its gain integrator.
// Optional leak control port appears when NORMALIZER_INT_LEAK_EN is defined.
interface red_pitaya_normalizer_integrator_if #(
   parameter int SIGNALBITS = 14,
   parameter int GAINBITS   = 14,
   parameter int DECBITS    = 4
);
   logic signed [SIGNALBITS-1:0] error_i;
   logic                         error_valid_i;
   logic signed [GAINBITS-1:0]   ki_i;
   logic        [SIGNALBITS-1:0] ival_i;
   logic                         ival_write_i;
   logic                         hold_i;
   logic        [DECBITS-1:0]    decim_i;
`ifdef NORMALIZER_INT_LEAK_EN
   logic        [4:0]            leak_i;
`endif
   logic        [SIGNALBITS-1:0] gain_o;
   logic                         gain_valid_o;
   logic                         sat_hi_o;
   logic                         sat_lo_o;

   // Controller / normalizer side: drives error and configuration
   modport master (
`ifdef NORMALIZER_INT_LEAK_EN
      output leak_i,
`endif
      output error_i, error_valid_i, ki_i, ival_i, ival_write_i, hold_i, decim_i,
      input  gain_o, gain_valid_o, sat_hi_o, sat_lo_o
   );

   // Integrator side
   modport slave (
`ifdef NORMALIZER_INT_LEAK_EN
      input  leak_i,
`endif
      input  error_i, error_valid_i, ki_i, ival_i, ival_write_i, hold_i, decim_i,
      output gain_o, gain_valid_o, sat_hi_o, sat_lo_o
   );
endinterface

// File: rtl/red_pitaya_normalizer_integrator.sv
// Gain integrator closing the normalizer loop: decimated error integration
// with ki, clamped accumulator, preset load, hold and saturation flags.
// Optional leak toward unity gain: define NORMALIZER_INT_LEAK_EN.
module red_pitaya_normalizer_integrator #(
   parameter int SIGNALBITS = 14,
   parameter int GAINBITS   = 14,
   parameter int ISR        = 32,
   parameter int DECBITS    = 4
) (
   input logic clk_i,
   input logic rst_i,
   red_pitaya_normalizer_integrator_if.slave bus
);
   localparam int IBW = ISR + SIGNALBITS + 2;
   localparam int PW  = SIGNALBITS + GAINBITS;
   // Sum is wide enough for both the accumulator and a full-scale product.
   localparam int SW  = ((IBW > PW) ? IBW : PW) + 1;
   localparam int CW  = 2**DECBITS - 1;

   localparam logic [SW-1:0]  LO_EXT = SW'(1) << ISR;
   localparam logic [SW-1:0]  HI_EXT = (SW'(1) << (ISR + SIGNALBITS)) - SW'(1);
   localparam logic [IBW-1:0] LO     = LO_EXT[IBW-1:0];
   localparam logic [IBW-1:0] HI     = HI_EXT[IBW-1:0];

   logic        [IBW-1:0]        int_reg;
   logic        [IBW-1:0]        int_next;
   logic signed [PW-1:0]         ki_mult;
   logic                         s1_valid;
   logic                         upd;
   logic        [CW-1:0]         cnt;
   logic        [CW-1:0]         lim;
   logic        [DECBITS-1:0]    decim_reg;
   logic                         decim_change;
   logic                         tick;
   logic signed [SW-1:0]         int_sum;
   logic        [SIGNALBITS-1:0] ival_eff;

   // Decimation compare, accumulator sum with clamp, and preset sanitising
   always_comb begin
      lim          = {CW{1'b1}} >> (CW - int'(decim_reg));
      decim_change = (bus.decim_i != decim_reg);
      tick         = bus.error_valid_i && !decim_change && (cnt == lim);
      int_sum      = {{(SW-PW){ki_mult[PW-1]}}, ki_mult} + {{(SW-IBW){1'b0}}, int_reg};
`ifdef NORMALIZER_INT_LEAK_EN
      if (bus.leak_i != 5'd31)
         int_sum = int_sum - {{(SW-IBW){1'b0}}, (int_reg >> ({1'b0, bus.leak_i} + 6'd1))};
`endif
      if (int_sum < $signed(LO_EXT))
         int_next = LO;
      else if (int_sum > $signed(HI_EXT))
         int_next = HI;
      else
         int_next = int_sum[IBW-1:0];
      ival_eff = (bus.ival_i == '0) ? SIGNALBITS'(1) : bus.ival_i;
   end

   // Three-stage pipeline: product, accumulate/clamp, publish gain and flags
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         int_reg          <= LO;
         ki_mult          <= '0;
         s1_valid         <= 1'b0;
         upd              <= 1'b0;
         cnt              <= '0;
         decim_reg        <= '0;
         bus.gain_o       <= SIGNALBITS'(1);
         bus.gain_valid_o <= 1'b0;
         bus.sat_hi_o     <= 1'b0;
         bus.sat_lo_o     <= 1'b0;
      end else begin
         decim_reg <= bus.decim_i;

         // An accumulator change already made (or a preset) always reaches
         // gain_o, so gain_o never disagrees with int_reg after a hold starts.
         bus.gain_valid_o <= upd;
         if (upd) begin
            bus.gain_o   <= int_reg[ISR+SIGNALBITS-1:ISR];
            bus.sat_hi_o <= (int_reg == HI);
            bus.sat_lo_o <= (int_reg == LO);
         end

         if (bus.ival_write_i) begin
            int_reg  <= {2'b00, ival_eff, {ISR{1'b0}}};
            s1_valid <= 1'b0;
            cnt      <= '0;
            upd      <= 1'b1;
         end else if (bus.hold_i) begin
            s1_valid <= 1'b0;
            upd      <= 1'b0;
            if (decim_change)
               cnt <= '0;
         end else begin
            if (decim_change)
               cnt <= '0;
            else if (bus.error_valid_i)
               cnt <= (cnt == lim) ? '0 : cnt + CW'(1);
            s1_valid <= tick;
            if (tick)
               ki_mult <= PW'(bus.error_i) * PW'(bus.ki_i);
            upd <= s1_valid;
            if (s1_valid)
               int_reg <= int_next;
         end
      end
   end
endmodule

// File: tb/tb_red_pitaya_normalizer_integrator.sv
// Directed bench for the normalizer gain integrator (ISR=4 so gain steps
// are easy to hand-compute: int_reg = gain*16 + fraction).
module tb_red_pitaya_normalizer_integrator;
   localparam int SB = 14;
   localparam int GB = 14;
   localparam int DB = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   strobes = 0;
   int   base;
   longint model;

   always #5 clk = ~clk;

   red_pitaya_normalizer_integrator_if #(.SIGNALBITS(SB), .GAINBITS(GB), .DECBITS(DB)) bus ();

   red_pitaya_normalizer_integrator #(
      .SIGNALBITS(SB), .GAINBITS(GB), .ISR(4), .DECBITS(DB)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.slave)
   );

   // Count gain strobes away from the active edge
   always @(negedge clk) if (bus.gain_valid_o === 1'b1) strobes++;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else
         $display("ok   %s: %0d", tag, got);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic preset(input int v);
      bus.ival_i       = SB'(v);
      bus.ival_write_i = 1'b1;
      step(1);
      bus.ival_write_i = 1'b0;
      step(2);
   endtask

   task automatic sample(input int e, input int k);
      bus.error_i       = SB'(e);
      bus.ki_i          = GB'(k);
      bus.error_valid_i = 1'b1;
      step(1);
      bus.error_valid_i = 1'b0;
      step(3);
   endtask

   initial begin
      bus.error_i       = '0;
      bus.error_valid_i = 1'b0;
      bus.ki_i          = '0;
      bus.ival_i        = '0;
      bus.ival_write_i  = 1'b0;
      bus.hold_i        = 1'b0;
      bus.decim_i       = '0;
`ifdef NORMALIZER_INT_LEAK_EN
      bus.leak_i        = 5'd31;
`endif
      // Reset state
      step(3);
      check("rst_gain", bus.gain_o, 1);
      check("rst_valid", bus.gain_valid_o, 0);
      check("rst_sat_hi", bus.sat_hi_o, 0);
      check("rst_sat_lo", bus.sat_lo_o, 0);
      rst = 1'b0;
      step(2);

      // Preset load: gain follows one cycle after the write, single strobe
      bus.ival_i       = 14'd100;
      bus.ival_write_i = 1'b1;
      step(1);
      bus.ival_write_i = 1'b0;
      check("pre_valid_early", bus.gain_valid_o, 0);
      step(1);
      check("pre_gain", bus.gain_o, 100);
      check("pre_valid", bus.gain_valid_o, 1);
      step(1);
      check("pre_valid_off", bus.gain_valid_o, 0);

      // Integration, decim 0: +1 gain per sample, 3-cycle latency
      bus.error_i       = 14'sd1;
      bus.ki_i          = 14'sd16;
      bus.error_valid_i = 1'b1;
      step(2);
      check("int_lat2", bus.gain_o, 100);
      step(1);
      check("int_g101", bus.gain_o, 101);
      step(1);
      check("int_g102", bus.gain_o, 102);
      step(1);
      check("int_g103", bus.gain_o, 103);

      // Asynchronous reset mid-stream, between clock edges
      #3;
      rst = 1'b1;
      #1;
      check("arst_gain", bus.gain_o, 1);
      check("arst_valid", bus.gain_valid_o, 0);
      check("arst_sat", {bus.sat_hi_o, bus.sat_lo_o}, 0);
      bus.error_valid_i = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);

      // Clamp at the top, leave it, then slam to the bottom
      preset(16000);
      sample(8191, 8191);
      check("clamp_hi_gain", bus.gain_o, 16383);
      check("clamp_hi_flag", {bus.sat_hi_o, bus.sat_lo_o}, 2);
      sample(8191, 8191);
      check("clamp_hi_stay", bus.gain_o, 16383);
      check("clamp_hi_flag2", bus.sat_hi_o, 1);
      sample(-1, 16);
      check("clamp_dn_gain", bus.gain_o, 16382);
      check("clamp_dn_flag", {bus.sat_hi_o, bus.sat_lo_o}, 0);
      sample(-8192, 8191);
      check("clamp_lo_gain", bus.gain_o, 1);
      check("clamp_lo_flag", {bus.sat_hi_o, bus.sat_lo_o}, 1);
      sample(-8192, 8191);
      check("clamp_lo_stay", bus.gain_o, 1);
      check("clamp_lo_flag2", bus.sat_lo_o, 1);

      // Decimation by 4, then a decim change mid-count must not tick
      bus.decim_i = 4'd2;
      step(2);
      preset(100);
      base = strobes;
      bus.error_i       = 14'sd1;
      bus.ki_i          = 14'sd16;
      bus.error_valid_i = 1'b1;
      step(4);
      bus.error_valid_i = 1'b0;
      step(3);
      check("dec4_gain", bus.gain_o, 101);
      check("dec4_strobes", strobes - base, 1);
      bus.error_valid_i = 1'b1;
      step(3);
      bus.decim_i = 4'd0;
      step(1);
      bus.error_valid_i = 1'b0;
      step(3);
      check("dec_change_notick", bus.gain_o, 101);
      bus.error_valid_i = 1'b1;
      step(2);
      bus.error_valid_i = 1'b0;
      step(3);
      check("dec0_gain", bus.gain_o, 103);

      // Hold with valid data: no movement, no strobes; fresh samples after
      preset(200);
      base = strobes;
      bus.error_i       = 14'sd1;
      bus.ki_i          = 14'sd16;
      bus.error_valid_i = 1'b1;
      bus.hold_i        = 1'b1;
      step(10);
      check("hold_gain", bus.gain_o, 200);
      check("hold_strobes", strobes - base, 0);
      bus.hold_i = 1'b0;
      step(2);
      check("unhold_lat2", bus.gain_o, 200);
      step(1);
      check("unhold_gain", bus.gain_o, 201);
      bus.error_valid_i = 1'b0;
      step(3);

      // Preset and hold in the same cycle with ival 0: write wins, forced to 1
      bus.hold_i       = 1'b1;
      bus.ival_i       = '0;
      bus.ival_write_i = 1'b1;
      step(1);
      bus.ival_write_i = 1'b0;
      bus.hold_i       = 1'b0;
      step(1);
      check("coll_gain", bus.gain_o, 1);
      check("coll_sat_lo", bus.sat_lo_o, 1);

`ifdef NORMALIZER_INT_LEAK_EN
      // Leak: int -= int >> (leak+1) per update, decaying toward 1
      preset(1000);
      bus.leak_i = 5'd3;
      model = 16000;
      for (int i = 0; i < 4; i++) begin
         sample(0, 16);
         model = model - (model >>> 4);
         if (model < 16) model = 16;
         check("leak_decay", bus.gain_o, model >>> 4);
      end
      bus.leak_i = 5'd31;
      preset(1000);
      sample(0, 16);
      sample(0, 16);
      check("leak_off", bus.gain_o, 1000);
`else
      // Pure integrator: zero error leaves the gain bit-exact
      preset(1000);
      model = 1000;
      for (int i = 0; i < 3; i++) begin
         sample(0, 8191);
         check("zero_err", bus.gain_o, model);
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/red_pitaya_normalizer_integrator.md
Name: red_pitaya_normalizer_integrator

Overview:
- Gain integrator that closes the loop of the normalizer stage.
- Consumes the signed error the normalizer produces (setpoint minus |input|·gain) and integrates it with a programmable ki.
- Delivers the clamped unsigned multiplication factor (1 .. 2**SIGNALBITS-1) that the normalizer multiplies its rectified input by.
- Supports decimated updates, hold, preset load and anti-windup saturation flags.

Parameters:
- SIGNALBITS, 14, width of error_i and gain_o.
- GAINBITS, 14, width of signed ki_i.
- ISR, 32, integrator fractional bits; gain = int_reg >> ISR.
- DECBITS, 4, width of decim_i; update every 2**decim_i valid samples.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- error_i  in  SIGNALBITS  signed error from normalizer.
- error_valid_i  in  1  error_i qualifier.
- ki_i  in  GAINBITS  signed integral gain.
- ival_i  in  SIGNALBITS  unsigned preset gain.
- ival_write_i  in  1  one-cycle pulse: load preset.
- hold_i  in  1  freeze integrator while high.
- decim_i  in  DECBITS  log2 decimation factor.
- gain_o  out  SIGNALBITS  unsigned gain to normalizer, range 1 .. 2**SIGNALBITS-1.
- gain_valid_o  out  1  one-cycle strobe when gain_o updates.
- sat_hi_o  out  1  accumulator pinned at upper limit.
- sat_lo_o  out  1  accumulator pinned at lower limit.

Behaviour:
- Reset (async, rst_i=1): int_reg = 1<<ISR, gain_o = 1, gain_valid_o = 0, sat_hi_o = 0, sat_lo_o = 0, decimation counter = 0, stage-1 valid = 0.
- Decimation:
  - Counter (2**DECBITS-1 bits wide) increments on each error_valid_i.
  - Tick when counter == 2**decim_i-1, then counter wraps to 0.
  - decim_i = 0 means a tick on every valid sample.
  - Any change of decim_i (registered compare) clears the counter without producing a tick.
- Pipeline:
  - Stage 1 (tick cycle n): ki_mult <= error_i*ki_i, full width SIGNALBITS+GAINBITS signed; s1_valid <= 1.
  - Stage 2 (n+1): int_sum = sign-extended ki_mult + int_reg, width IBW+1 with IBW = ISR+SIGNALBITS+2.
  - Stage 2 clamp: int_reg <= clamp(int_sum, LO=1<<ISR, HI=((2**SIGNALBITS-1)<<ISR) | (2**ISR-1)).
  - Stage 3 (n+2): gain_o <= int_reg[ISR+SIGNALBITS-1:ISR]; gain_valid_o = 1 for one cycle.
  - Total latency: accepted sample to gain_o is 3 cycles.
- Saturation: sat_hi_o / sat_lo_o are registered with gain_o. Each is 1 while int_reg equals HI / LO respectively; never both at once.
- Priority per cycle: rst_i > ival_write_i > hold_i > normal update.
- ival_write_i:
  - Loads int_reg <= {ival_i, ISR zeros}; ival_i = 0 is forced to 1.
  - Clears s1_valid, discarding any in-flight product.
  - Clears the decimation counter.
  - gain_o and gain_valid_o follow next cycle.
- hold_i = 1:
  - int_reg and the counter are frozen.
  - Incoming samples and the in-flight product are discarded.
  - gain_o is held and gain_valid_o = 0.
  - After hold falls, the first tick needs 2**decim_i fresh samples.
- A tick coinciding with a stage-2 update is fully pipelined; no sample is dropped.
- ki_i is sampled at stage 1 only; changing it mid-stream affects the next tick.

Optional Feature:
- Macro: NORMALIZER_INT_LEAK_EN.
- Defined: adds input leak_i [4:0]. Each stage-2 update subtracts int_reg >>> (leak_i+1) before the clamp, so the gain decays toward 1 when error is zero. leak_i = 31 is treated as leak off.
- Undefined: port absent, pure integrator. A zero error leaves int_reg unchanged bit-exactly.

Test Plan:
- Reset: assert rst_i asynchronously mid-stream -> same edge gain_o=1, flags 0; after release, ival_write_i with ival_i=100 -> gain_o=100 next cycle, gain_valid_o one pulse.
- Integration (ISR=4, decim_i=0): preset 100, ki_i=16, error_i=+1 valid continuous -> gain_o 101,102,103 on consecutive cycles, first change 3 cycles after first valid.
- Clamp: ki_i=max, error_i=+8191 continuous -> gain_o reaches 16383, sat_hi_o=1, stays; switch error_i=-8192 -> decreases next ticks, sat_hi_o falls; run to bottom -> gain_o=1, sat_lo_o=1, never 0.
- Decimation (ISR=4): decim_i=2, ki_i=16, error_i=+1 -> gain_o increments once per 4 valid samples; changing decim_i to 0 mid-count -> counter cleared, no spurious tick.
- Hold/preset collision: hold_i=1 for 10 cycles with valid data -> gain_o constant, no strobes; same cycle ival_write_i=1 and hold_i=1 with ival_i=0 -> gain_o=1 (write wins, zero forced to 1).
- Leak (macro defined, ISR=4): preset 1000, error_i=0, leak_i=3 -> gain_o decays monotonically toward 1; leak_i=31 -> gain_o stays 1000.
